// File: rtl/compare_iter_if.sv
`default_nettype none
// ============================================================================
// Package      : types
// Interface    : compare_iter_if
// Description  : Shared compare-operation encoding plus the valid/ready bus
//                bundle for compare_iter.
//                master : requester side (drives request, consumes result)
//                slave  : compare_iter side
// Signals      : in_valid/in_ready      request handshake
//                operand_a/operand_b    WIDTH-bit operands
//                cmp_op                 compare operation (cmp_op_t)
//                out_valid/out_ready    result handshake
//                result                 1-bit comparison outcome
// Revision     : 1.0 - initial release
// ============================================================================
package types;
  // Encodings 6 and 7 are unused; compare_iter reports result=0 for them.
  typedef enum logic [2:0] {
    CMP_EQ  = 3'd0,
    CMP_NE  = 3'd1,
    CMP_LT  = 3'd2,
    CMP_GE  = 3'd3,
    CMP_LTU = 3'd4,
    CMP_GEU = 3'd5
  } cmp_op_t;
endpackage

interface compare_iter_if #(
  parameter int WIDTH = 32
) ();
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   operand_a;
  logic [WIDTH-1:0]   operand_b;
  types::cmp_op_t     cmp_op;
  logic               out_valid;
  logic               out_ready;
  logic               result;

  modport master (
    output in_valid, operand_a, operand_b, cmp_op, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, operand_a, operand_b, cmp_op, out_ready,
    output in_ready, out_valid, result
  );
endinterface
`default_nettype wire

// File: rtl/compare_iter.sv
`default_nettype none
// ============================================================================
// Module       : compare_iter
// Description  : Iterative RISC-V branch comparator. Evaluates EQ/NE/LT/GE/
//                LTU/GEU on WIDTH-bit operands CHUNK bits per cycle, MSB
//                chunk first, with valid/ready handshakes on both sides.
// Parameters   : WIDTH  operand width (default 32)
//                CHUNK  bits compared per cycle (default 8); WIDTH % CHUNK
//                       must be 0 and CHUNK <= WIDTH
// Ports        : clk    clock, all state updates on posedge
//                rst    synchronous active-high reset
//                bus    compare_iter_if.slave (request + result handshakes)
// Build option : CMP_EARLY_EXIT_EN - when defined, leave RUN on the first
//                differing chunk instead of always running N steps.
// Revision     : 1.0 - initial release
// ============================================================================
module compare_iter #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic           clk,
  input  logic           rst,
  compare_iter_if.slave  bus
);
  import types::*;

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  generate
    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
      $error("compare_iter: CHUNK must divide WIDTH and not exceed it");
    end
  endgenerate

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  cmp_op_t          op_q;
  logic [CW-1:0]    cnt;
  logic             decided;
  logic             lt;

  // Inverting the sign bit maps two's-complement order onto unsigned order,
  // so a single unsigned chunk comparator serves every op.
  logic             is_signed;
  logic [WIDTH-1:0] sign_flip;
  assign is_signed = (bus.cmp_op == CMP_LT) || (bus.cmp_op == CMP_GE);
  assign sign_flip = WIDTH'(is_signed) << (WIDTH - 1);

  // Operands are shifted left each step, so the chunk under test is always
  // the top CHUNK bits; this equals chunk k of the latched operands.
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic             first_diff;
  assign chunk_a    = a_sh[WIDTH-1 -: CHUNK];
  assign chunk_b    = b_sh[WIDTH-1 -: CHUNK];
  assign first_diff = !decided && (chunk_a != chunk_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      op_q    <= CMP_EQ;
      cnt     <= '0;
      decided <= 1'b0;
      lt      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh    <= bus.operand_a ^ sign_flip;
            b_sh    <= bus.operand_b ^ sign_flip;
            op_q    <= bus.cmp_op;
            cnt     <= '0;
            decided <= 1'b0;
            lt      <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (first_diff) begin
            decided <= 1'b1;
            lt      <= (chunk_a < chunk_b);
          end
          a_sh <= a_sh << CHUNK;
          b_sh <= b_sh << CHUNK;
`ifdef CMP_EARLY_EXIT_EN
          if (first_diff || (cnt == LAST)) begin
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`else
          if (cnt == LAST) begin
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic res;
  always_comb begin
    res = 1'b0;
    if (state == DONE) begin
      case (op_q)
        CMP_EQ:  res = !decided;
        CMP_NE:  res = decided;
        CMP_LT:  res = lt;
        CMP_LTU: res = lt;
        CMP_GE:  res = !lt;
        CMP_GEU: res = !lt;
        default: res = 1'b0;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = res;

endmodule
`default_nettype wire

// File: tb/tb_compare_iter.sv
`default_nettype none
// ============================================================================
// Module       : tb_compare_iter
// Description  : Self-checking bench for compare_iter. Three instances
//                (32/8, 64/16, 32/32) share one stimulus driver selected by
//                'sel'. Results and latencies are checked against a
//                behavioural model built from signed/unsigned arithmetic.
// Revision     : 1.0 - initial release
// ============================================================================
module tb_compare_iter;
  import types::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int          sel = 0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] tb_a = '0;
  logic [63:0] tb_b = '0;
  cmp_op_t     tb_op = CMP_EQ;

  int W [3] = '{32, 64, 32};
  int C [3] = '{8, 16, 32};

  compare_iter_if #(.WIDTH(32)) bus0 ();
  compare_iter_if #(.WIDTH(64)) bus1 ();
  compare_iter_if #(.WIDTH(32)) bus2 ();

  assign bus0.in_valid  = in_valid && (sel == 0);
  assign bus0.operand_a = tb_a[31:0];
  assign bus0.operand_b = tb_b[31:0];
  assign bus0.cmp_op    = tb_op;
  assign bus0.out_ready = out_ready;

  assign bus1.in_valid  = in_valid && (sel == 1);
  assign bus1.operand_a = tb_a;
  assign bus1.operand_b = tb_b;
  assign bus1.cmp_op    = tb_op;
  assign bus1.out_ready = out_ready;

  assign bus2.in_valid  = in_valid && (sel == 2);
  assign bus2.operand_a = tb_a[31:0];
  assign bus2.operand_b = tb_b[31:0];
  assign bus2.cmp_op    = tb_op;
  assign bus2.out_ready = out_ready;

  compare_iter #(.WIDTH(32), .CHUNK(8))  dut0 (.clk(clk), .rst(rst), .bus(bus0));
  compare_iter #(.WIDTH(64), .CHUNK(16)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  compare_iter #(.WIDTH(32), .CHUNK(32)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  logic m_in_ready, m_out_valid, m_result;
  always_comb begin
    m_in_ready  = bus0.in_ready;
    m_out_valid = bus0.out_valid;
    m_result    = bus0.result;
    if (sel == 1) begin
      m_in_ready  = bus1.in_ready;
      m_out_valid = bus1.out_valid;
      m_result    = bus1.result;
    end else if (sel == 2) begin
      m_in_ready  = bus2.in_ready;
      m_out_valid = bus2.out_valid;
      m_result    = bus2.result;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result from plain signed/unsigned arithmetic.
  function automatic logic ref_res(input logic [2:0] op, input logic [63:0] a,
                                   input logic [63:0] b, input int w);
    logic [63:0] ua, ub;
    longint sa, sb;
    if (w == 64) begin
      ua = a; ub = b; sa = a; sb = b;
    end else begin
      ua = {32'h0, a[31:0]}; ub = {32'h0, b[31:0]};
      sa = $signed(a[31:0]); sb = $signed(b[31:0]);
    end
    case (op)
      3'd0:    return ua == ub;
      3'd1:    return ua != ub;
      3'd2:    return sa < sb;
      3'd3:    return sa >= sb;
      3'd4:    return ua < ub;
      3'd5:    return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  // Expected cycles from accept edge to out_valid.
  function automatic int ref_lat(input logic [63:0] a, input logic [63:0] b,
                                 input int w, input int ch);
    int n = w / ch;
`ifdef CMP_EARLY_EXIT_EN
    logic [63:0] x = a ^ b;
    for (int p = w - 1; p >= 0; p--) begin
      if (x[p]) return (w - 1 - p) / ch + 1;
    end
`endif
    return n;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!m_in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_timeout", {63'h0, m_in_ready}, 64'h1);
  endtask

  // Wait (bounded) for out_valid after an accept; returns cycles counted.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!m_out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk("out_valid_timeout", {63'h0, m_out_valid}, 64'h1);
  endtask

  task automatic do_op(input int s, input cmp_op_t op, input logic [63:0] a,
                       input logic [63:0] b, input string tag);
    int lat;
    sel = s;
    out_ready = 1'b1;
    wait_ready();
    tb_a = a; tb_b = b; tb_op = op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    chk({tag, "_result"}, {63'h0, m_result}, {63'h0, ref_res(op, a, b, W[s])});
    chk({tag, "_latency"}, 64'(lat), 64'(ref_lat(a, b, W[s], C[s])));
    @(posedge clk); #1;
    chk({tag, "_ready_after"}, {63'h0, m_in_ready}, 64'h1);
  endtask

  initial begin
    int lat;
    int hits;
    logic [63:0] ra, rb;

    // Reset values on every instance while rst is held.
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      chk("rst_in_ready", {63'h0, m_in_ready}, 64'h1);
      chk("rst_out_valid", {63'h0, m_out_valid}, 64'h0);
      chk("rst_result", {63'h0, m_result}, 64'h0);
    end
    sel = 0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases on WIDTH=32/CHUNK=8.
    do_op(0, CMP_EQ,  64'h12345678, 64'h12345678, "eq_equal");
    do_op(0, CMP_LT,  64'h80000000, 64'h7FFFFFFF, "lt_msb");
    do_op(0, CMP_GE,  64'h80000000, 64'h7FFFFFFF, "ge_msb");
    do_op(0, CMP_LTU, 64'h00000001, 64'h00000002, "ltu_lsb");
    do_op(0, CMP_GEU, 64'hFFFFFFFF, 64'h00000000, "geu_max");
    do_op(0, CMP_LTU, 64'h7FFFFFFF, 64'h80000000, "ltu_msb");
    do_op(0, CMP_NE,  64'h00000000, 64'h00000000, "ne_equal");
    do_op(0, cmp_op_t'(3'd6), 64'h1, 64'h2, "bad_op");
    do_op(2, CMP_LT,  64'hFFFFFFFF, 64'h00000000, "n1_lt");

    // Backpressure: result held, new request ignored until handshake.
    sel = 0; out_ready = 1'b0;
    wait_ready();
    tb_a = 64'h80000000; tb_b = 64'h7FFFFFFF; tb_op = CMP_LT; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    tb_a = 64'h5; tb_b = 64'h5; tb_op = CMP_EQ; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", {63'h0, m_out_valid}, 64'h1);
      chk("bp_result", {63'h0, m_result}, 64'h1);
      chk("bp_in_ready", {63'h0, m_in_ready}, 64'h0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_hs_out_valid", {63'h0, m_out_valid}, 64'h0);
    chk("bp_hs_in_ready", {63'h0, m_in_ready}, 64'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accepted", {63'h0, m_in_ready}, 64'h0);
    wait_valid(lat);
    chk("bp_next_result", {63'h0, m_result}, 64'h1);
    chk("bp_next_latency", 64'(lat), 64'd4);
    @(posedge clk); #1;

    // Reset after two RUN cycles discards the pending result.
    sel = 0;
    wait_ready();
    tb_a = 64'hCAFE0001; tb_b = 64'hCAFE0001; tb_op = CMP_EQ; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", {63'h0, m_out_valid}, 64'h0);
    chk("midrst_result", {63'h0, m_result}, 64'h0);
    chk("midrst_in_ready", {63'h0, m_in_ready}, 64'h1);
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (m_out_valid) hits++;
    end
    chk("midrst_no_pulse", 64'(hits), 64'd0);
    do_op(0, CMP_NE, 64'h0, 64'h1, "ne_after_rst");

    // rst and in_valid together: nothing accepted.
    wait_ready();
    tb_a = 64'h1; tb_b = 64'h2; tb_op = CMP_LTU; in_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_wins_in_ready", {63'h0, m_in_ready}, 64'h1);
    chk("rst_wins_out_valid", {63'h0, m_out_valid}, 64'h0);

    // Random regression; operands biased so shared upper chunks are common.
    for (int s = 0; s < 3; s++) begin
      int reps = (s == 0) ? 200 : 1000;
      for (int i = 0; i < reps; i++) begin
        ra = {$urandom, $urandom};
        case ($urandom_range(0, 3))
          0:       rb = {$urandom, $urandom};
          1:       rb = ra;
          2:       rb = ra ^ (64'h1 << $urandom_range(0, W[s] - 1));
          default: rb = ra ^ {32'h0, $urandom};
        endcase
        if (W[s] == 32) begin
          ra[63:32] = '0;
          rb[63:32] = '0;
        end
        do_op(s, cmp_op_t'(3'($urandom_range(0, 7))), ra, rb, "rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
